permutation_pipe: RTL and testbench
===================================

// Module: permutation_pipe
// PURPOSE
// - Parametrised, pipelined successor of the 64-bit PRESENT bit-permutation layer.
// - Applies the generalised pLayer, forward (encrypt) or inverse (decrypt), selected per beat.
// - Carries data through STAGES registered stages under valid/ready flow control.
// - Sits between the sBox layer and round-key addition in round-iterative or unrolled cores.
// PARAMETERS
// - WIDTH   64  state width in bits. Multiple of 4, >= 8. S = WIDTH/4 sBox nibbles.
// - STAGES  1   register stages, 1..4. Latency in cycles.
// PORTS
// - clk_i    in   1      clock, rising edge
// - rst_i    in   1      asynchronous, active-high reset
// - valid_i  in   1      input beat valid
// - ready_o  out  1      block can accept a beat this cycle
// - inv_i    in   1      0 = forward pLayer, 1 = inverse pLayer; sampled with the beat
// - data_i   in   WIDTH  input state
// - valid_o  out  1      output beat valid
// - ready_i  in   1      downstream accepts the output beat
// - inv_o    out  1      inv_i of the beat currently on data_o
// - data_o   out  WIDTH  permuted state
// BEHAVIOUR
// - Forward map: data_i[i] -> out[(i%4)*S + i/4], for i = 0..WIDTH-1.
//   - For WIDTH=64 this equals PRESENT P(i) = 16*i mod 63, with P(63) = 63.
// - Inverse map: data_i[j] -> out[(j%S)*4 + j/S]. inv(fwd(x)) == x for all x.
// - The permutation is combinational on data_i and sits before stage 0. Stages 1..STAGES-1 are plain registers.
// - Handshake:
//   - A beat transfers when valid & ready are both high on the same rising edge.
//   - Each stage k holds v[k], d[k], m[k].
//   - Stage k loads when it is empty or stage k+1 loads in the same cycle.
//     - For the last stage, stage k+1 loading means ready_i.
//   - ready_o = !v[0] | (stage 0 advancing). ready_o is combinational from ready_i and stage valids.
//   - valid_o = v[STAGES-1]; data_o = d[STAGES-1]; inv_o = m[STAGES-1].
//   - While valid_o & !ready_i, data_o and inv_o hold stable. No beat is dropped or duplicated.
//   - Throughput is 1 beat/cycle with ready_i held high. Latency = STAGES cycles from input transfer to valid_o.
//   - A full pipe with ready_i=0 holds STAGES beats.
//     - While ready_i=0, ready_o=0.
//     - On the cycle ready_i rises, ready_o=1 and the pipe drains/refills without a bubble.
//   - valid_i may drop without a transfer. data_i/inv_i are don't-care when valid_i=0.
//     - Stage valid bits do not set from a non-valid input.
// - Reset (async assert, sampled release):
//   - All v[k]=0, d[k]=0, m[k]=0.
//   - Therefore valid_o=0, data_o=0, inv_o=0, and ready_o=1 once rst_i is low.
//   - Reset mid-operation discards every in-flight beat. No output beat appears after reset until a new input transfer.
// - Simultaneous input and output transfer on a full pipe is legal. Occupancy stays constant.
// - Elaboration errors on WIDTH%4 != 0, WIDTH < 8, or STAGES outside 1..4.
// TESTING
// - WIDTH=64, fwd, data_i=64'h0000_0000_0000_0002 -> data_o=64'h0000_0000_0001_0000 after STAGES cycles.
// - WIDTH=64, fwd, 64'h0000_0000_0000_000F -> 64'h0001_0001_0001_0001.
//   - Same case, 64'h8000_0000_0000_0001 -> unchanged.
// - WIDTH=64, inv, 64'h0000_0000_0001_0000 -> 64'h0000_0000_0000_0002.
//   - Random 1000 beats through fwd then inv -> original data; inv_o matches inv_i per beat.
// - Backpressure: hold ready_i=0, stream 6 beats (STAGES=3).
//   - Only 3 accepted; ready_o=0; data_o stable.
//   - Release ready_i -> beats exit in order, no loss/duplication, 1/cycle.
// - Reset: assert rst_i with 2 beats in flight.
//   - valid_o=0 and data_o=0 immediately (async).
//   - After release, no stale beat ever emerges.
// - WIDTH=16, STAGES=1, fwd, 16'h0002 -> 16'h0010.
//   - Same configuration, inv 16'h0010 -> 16'h0002.
//   - Random valid_i/ready_i toggling is checked against a scoreboard.

Source files
------------

// File: rtl/permutation_pipe.sv
// Generalised PRESENT pLayer (forward/inverse per beat) followed by STAGES register stages.
// Latency STAGES cycles, 1 beat/cycle; valid/ready backpressure ripples combinationally, so a full pipe refills without a bubble.
module permutation_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             inv_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             inv_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int S = WIDTH / 4;

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("permutation_pipe: WIDTH must be a multiple of 4 and at least 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("permutation_pipe: STAGES must be in 1..4");
    end

    logic [WIDTH-1:0] fwd_perm;
    logic [WIDTH-1:0] inv_perm;
    logic [WIDTH-1:0] perm;

    // Pure wiring: bit i goes to nibble-lane (i%4), position i/4, and back.
    for (genvar i = 0; i < WIDTH; i++) begin : g_perm
        assign fwd_perm[(i % 4) * S + i / 4] = data_i[i];
        assign inv_perm[(i % S) * 4 + i / S] = data_i[i];
    end

    assign perm = inv_i ? inv_perm : fwd_perm;

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] m_q, m_d;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [WIDTH-1:0]  d_d [STAGES];
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_m;
    logic [WIDTH-1:0]  src_d [STAGES];

    always_comb begin
        logic full_tail;
        full_tail = 1'b1;
        src_v[0] = valid_i;
        src_m[0] = inv_i;
        src_d[0] = perm;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = v_q[k-1];
            src_m[k] = m_q[k-1];
            src_d[k] = d_q[k-1];
        end
        // A stage may load unless it and every stage after it are full and the sink stalls.
        for (int k = STAGES - 1; k >= 0; k--) begin
            full_tail = full_tail & v_q[k];
            load[k]   = ready_i | ~full_tail;
        end
        for (int k = 0; k < STAGES; k++) begin
            v_d[k] = v_q[k];
            m_d[k] = m_q[k];
            d_d[k] = d_q[k];
            if (load[k]) begin
                v_d[k] = src_v[k];
                if (src_v[k]) begin
                    m_d[k] = src_m[k];
                    d_d[k] = src_d[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q <= '0;
            m_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            m_q <= m_d;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

    assign ready_o = load[0];
    assign valid_o = v_q[STAGES-1];
    assign data_o  = d_q[STAGES-1];
    assign inv_o   = m_q[STAGES-1];

endmodule

// File: tb/tb_permutation_pipe.sv
// Scoreboard bench: WIDTH=64/STAGES=3 instance and WIDTH=16/STAGES=1 instance side by side.
module tb_permutation_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid_i = 1'b0, a_ready_o, a_inv_i = 1'b0, a_valid_o, a_ready_i = 1'b1, a_inv_o;
    logic [63:0] a_data_i = '0, a_data_o;
    logic        b_valid_i = 1'b0, b_ready_o, b_inv_i = 1'b0, b_valid_o, b_ready_i = 1'b1, b_inv_o;
    logic [15:0] b_data_i = '0, b_data_o;

    permutation_pipe #(.WIDTH(64), .STAGES(3)) u_a (
        .clk_i(clk), .rst_i(rst), .valid_i(a_valid_i), .ready_o(a_ready_o), .inv_i(a_inv_i),
        .data_i(a_data_i), .valid_o(a_valid_o), .ready_i(a_ready_i), .inv_o(a_inv_o), .data_o(a_data_o)
    );

    permutation_pipe #(.WIDTH(16), .STAGES(1)) u_b (
        .clk_i(clk), .rst_i(rst), .valid_i(b_valid_i), .ready_o(b_ready_o), .inv_i(b_inv_i),
        .data_i(b_data_i), .valid_o(b_valid_o), .ready_i(b_ready_i), .inv_o(b_inv_o), .data_o(b_data_o)
    );

    typedef struct {
        logic [63:0] d;
        logic        m;
    } beat_t;

    beat_t q_a[$];
    beat_t q_b[$];
    int n_cmp = 0;
    int n_bad = 0;
    int acc_a = 0;
    int out_a = 0;
    int out_b = 0;
    bit tog_a = 1'b0;
    bit tog_b = 1'b0;

    logic [63:0] bp_in [6] = '{64'h1, 64'h2, 64'h4, 64'h8, 64'h10, 64'h20};
    logic [63:0] bp_out[6] = '{64'h1, 64'h0000_0000_0001_0000, 64'h0000_0001_0000_0000,
                               64'h0001_0000_0000_0000, 64'h2, 64'h0000_0000_0002_0000};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // PRESENT-style reference: bit i moves to i*S mod (W-1), top bit fixed.
    function automatic logic [63:0] pmodel(input int w, input logic [63:0] x, input logic inv);
        logic [63:0] r;
        int p;
        r = '0;
        for (int i = 0; i < w; i++) begin
            p = (i == w - 1) ? i : (i * (w / 4)) % (w - 1);
            if (!inv) r[p] = x[i];
            else      r[i] = x[p];
        end
        return r;
    endfunction

    task automatic send(input int sel, input logic [63:0] d, input logic inv, input logic [63:0] exp);
        bit    ok;
        beat_t e;
        ok  = 1'b0;
        e.d = exp;
        e.m = inv;
        if (sel == 0) begin
            a_valid_i = 1'b1; a_data_i = d; a_inv_i = inv;
        end else begin
            b_valid_i = 1'b1; b_data_i = d[15:0]; b_inv_i = inv;
        end
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk);
            if ((sel == 0) ? a_ready_o : b_ready_o) begin
                ok = 1'b1;
                if (sel == 0) begin q_a.push_back(e); acc_a++; end
                else          q_b.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        if (sel == 0) a_valid_i = 1'b0;
        else          b_valid_i = 1'b0;
        if (!ok) check("send_accept", {63'b0, ok}, 64'h1);
    endtask

    task automatic drain(input int sel);
        for (int t = 0; t < 300; t++) begin
            if (((sel == 0) ? q_a.size() : q_b.size()) == 0) break;
            @(posedge clk);
            #1;
        end
        check((sel == 0) ? "a_drain" : "b_drain", (sel == 0) ? q_a.size() : q_b.size(), 64'h0);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!rst && a_valid_o && a_ready_i) begin
            out_a++;
            if (q_a.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL a_unexpected_beat: got data %h with no beat outstanding", a_data_o);
            end else begin
                e = q_a.pop_front();
                check("a_data", a_data_o, e.d);
                check("a_inv", {63'b0, a_inv_o}, {63'b0, e.m});
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (!rst && b_valid_o && b_ready_i) begin
            out_b++;
            if (q_b.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_unexpected_beat: got data %h with no beat outstanding", b_data_o);
            end else begin
                e = q_b.pop_front();
                check("b_data", {48'b0, b_data_o}, e.d);
                check("b_inv", {63'b0, b_inv_o}, {63'b0, e.m});
            end
        end
    end

    initial begin
        int          n;
        int          acc0;
        int          out0;
        logic [63:0] hold;
        logic [63:0] x;
        logic [63:0] y;
        logic        m;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_a_valid", {63'b0, a_valid_o}, 64'h0);
        check("rst_a_data", a_data_o, 64'h0);
        check("rst_a_inv", {63'b0, a_inv_o}, 64'h0);
        check("rst_a_ready", {63'b0, a_ready_o}, 64'h1);
        check("rst_b_valid", {63'b0, b_valid_o}, 64'h0);
        check("rst_b_ready", {63'b0, b_ready_o}, 64'h1);
        @(posedge clk);
        #1;

        // Directed vectors, WIDTH=64 / STAGES=3
        send(0, 64'h2, 1'b0, 64'h0000_0000_0001_0000);
        n = 1;
        while (!a_valid_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("a_latency", n, 64'd3);
        send(0, 64'h0000_0000_0000_000F, 1'b0, 64'h0001_0001_0001_0001);
        send(0, 64'h8000_0000_0000_0001, 1'b0, 64'h8000_0000_0000_0001);
        send(0, 64'h0000_0000_0001_0000, 1'b1, 64'h0000_0000_0000_0002);
        drain(0);

        // Directed vectors, WIDTH=16 / STAGES=1
        send(1, 64'h0002, 1'b0, 64'h0010);
        send(1, 64'h0010, 1'b1, 64'h0002);
        drain(1);

        // Backpressure: six beats offered into a stalled 3-deep pipe
        a_ready_i = 1'b0;
        acc0 = acc_a;
        fork
            begin
                for (int k = 0; k < 6; k++) send(0, bp_in[k], 1'b0, bp_out[k]);
            end
        join_none
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_accepted", acc_a - acc0, 64'd3);
        check("bp_ready_low", {63'b0, a_ready_o}, 64'h0);
        check("bp_valid_high", {63'b0, a_valid_o}, 64'h1);
        check("bp_head", a_data_o, bp_out[0]);
        hold = a_data_o;
        repeat (3) @(negedge clk);
        check("bp_stable", a_data_o, hold);
        @(posedge clk);
        #1;
        a_ready_i = 1'b1;
        out0 = out_a;
        repeat (6) @(posedge clk);
        #2;
        check("bp_rate", out_a - out0, 64'd6);
        drain(0);

        // Reset with two beats in flight
        send(0, 64'h1234_5678_9ABC_DEF0, 1'b0, pmodel(64, 64'h1234_5678_9ABC_DEF0, 1'b0));
        send(0, 64'hFFFF_0000_FFFF_0000, 1'b1, pmodel(64, 64'hFFFF_0000_FFFF_0000, 1'b1));
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {63'b0, a_valid_o}, 64'h0);
        check("arst_data", a_data_o, 64'h0);
        check("arst_inv", {63'b0, a_inv_o}, 64'h0);
        q_a.delete();
        out0 = out_a;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        check("arst_no_stale", out_a - out0, 64'h0);
        check("arst_valid_after", {63'b0, a_valid_o}, 64'h0);
        @(posedge clk);
        #1;

        // 1000 random beats: forward then inverse, with random output stalls
        tog_a = 1'b1;
        fork
            begin
                while (tog_a) begin
                    @(posedge clk);
                    #1;
                    a_ready_i = 1'($urandom_range(0, 1));
                end
                a_ready_i = 1'b1;
            end
        join_none
        for (int r = 0; r < 500; r++) begin
            x = {$urandom, $urandom};
            y = pmodel(64, x, 1'b0);
            send(0, x, 1'b0, y);
            send(0, y, 1'b1, x);
        end
        tog_a = 1'b0;
        drain(0);

        // Random valid/ready toggling on the 16-bit single-stage instance
        tog_b = 1'b1;
        fork
            begin
                while (tog_b) begin
                    @(posedge clk);
                    #1;
                    b_ready_i = 1'($urandom_range(0, 1));
                end
                b_ready_i = 1'b1;
            end
        join_none
        for (int r = 0; r < 300; r++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            x = {48'b0, 16'($urandom)};
            m = 1'($urandom_range(0, 1));
            send(1, x, m, pmodel(16, x, m));
        end
        tog_b = 1'b0;
        drain(1);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
